// File: rtl/vga_layer_compositor.sv
// VGA raster generator plus priority merge of drawing-object colors.
// It also keeps per-frame collision flags between the player layer and every other layer.
module vga_layer_compositor #(
  parameter int          N_LAYERS    = 4,
  parameter logic [7:0]  MASK_VALUE  = 8'h62,
  parameter logic [7:0]  BG_COLOR    = 8'h00,
  parameter int          OBJ_LATENCY = 1,
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_TOTAL     = 800,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_TOTAL     = 525
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [N_LAYERS-1:0][7:0] layer_color,
  output logic [10:0]              requested_x,
  output logic [10:0]              requested_y,
  output logic                     frame_start,
  output logic [7:0]               rgb_out,
  output logic                     hsync_n,
  output logic                     vsync_n,
  output logic                     blank_n,
  output logic [N_LAYERS-1:0]      collision_flags
);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } pix_flags_t;

  logic [9:0] r_h, r_v;
  logic [9:0] w_h_nxt, w_v_nxt;
  logic       r_fs;

  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (r_h == 10'(H_TOTAL-1)) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == 10'(V_TOTAL-1)) ? '0 : r_v + 10'd1;
    end
  end

  // frame_start is decoded from the next counter value, so it is high while the counters read (0, V_ACTIVE).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h  <= '0;
      r_v  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_h  <= w_h_nxt;
      r_v  <= w_v_nxt;
      r_fs <= (w_h_nxt == '0) && (w_v_nxt == 10'(V_ACTIVE));
    end
  end

  pix_flags_t w_raw;
  always_comb begin
    w_raw     = '0;
    w_raw.act = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
    w_raw.hs  = (r_h >= 10'(H_ACTIVE+H_FP)) && (r_h <= 10'(H_ACTIVE+H_FP+H_SYNC-1));
    w_raw.vs  = (r_v >= 10'(V_ACTIVE+V_FP)) && (r_v <= 10'(V_ACTIVE+V_FP+V_SYNC-1));
  end

  // Position flags ride along with the request until the object colors come back.
  pix_flags_t [OBJ_LATENCY-1:0] r_pipe;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_raw;
      for (int i = 1; i < OBJ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  pix_flags_t w_dly;
  assign w_dly = r_pipe[OBJ_LATENCY-1];

  logic [N_LAYERS-1:0] w_opaque;
  logic [N_LAYERS-1:0] w_hit;
  logic [7:0]          w_merge;

  generate
    for (genvar k = 0; k < N_LAYERS; k++) begin : g_lane
      assign w_opaque[k] = (layer_color[k] != MASK_VALUE);
      if (k == 0) begin : g_player
        assign w_hit[k] = 1'b0;
      end else begin : g_other
        assign w_hit[k] = w_dly.act & w_opaque[0] & w_opaque[k];
      end
    end
  endgenerate

  // Scan from lowest priority upward so the lowest opaque index wins.
  always_comb begin
    w_merge = BG_COLOR;
    for (int i = N_LAYERS-1; i >= 0; i--) begin
      if (w_opaque[i]) w_merge = layer_color[i];
    end
  end

  logic [7:0]          r_rgb;
  logic                r_hs_n, r_vs_n, r_blank_n;
  logic [N_LAYERS-1:0] r_acc, r_flags;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rgb     <= 8'h00;
      r_hs_n    <= 1'b1;
      r_vs_n    <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_rgb     <= w_dly.act ? w_merge : 8'h00;
      r_hs_n    <= ~w_dly.hs;
      r_vs_n    <= ~w_dly.vs;
      r_blank_n <= w_dly.act;
    end
  end

  // A hit in the frame_start cycle lands in the freshly cleared accumulator.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (r_fs) begin
      r_flags <= r_acc;
      r_acc   <= w_hit;
    end else begin
      r_acc   <= r_acc | w_hit;
    end
  end

  assign requested_x     = {1'b0, r_h};
  assign requested_y     = {1'b0, r_v};
  assign frame_start     = r_fs;
  assign rgb_out         = r_rgb;
  assign hsync_n         = r_hs_n;
  assign vsync_n         = r_vs_n;
  assign blank_n         = r_blank_n;
  assign collision_flags = r_flags;

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Pixel-side end of the object drawing interface. Drawing objects consume requested_x/requested_y/frame_start and return output_color; this block produces those three signals and consumes the colors.
- Generates 640x480 VGA raster timing at one pixel per clk.
- Drives the pixel request bus shared by all drawing objects and priority-merges their returned colors, treating 8'h62 as transparent.
- Detects per-frame overlaps between the player layer and every other layer, and delivers sync-aligned 8-bit RGB to the DAC.

Parameters:
N_LAYERS, 4, number of object color inputs; layer 0 = player, highest priority; higher index = lower priority
MASK_VALUE, 8'h62, transparent color code
BG_COLOR, 8'h00, color when all layers are transparent in the active area
OBJ_LATENCY, 1, clk cycles from request coordinates to valid layer color
H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_TOTAL, 800, horizontal timing in pixels
V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_TOTAL, 525, vertical timing in lines

Ports:
clk  in  1  pixel clock, one pixel per cycle
resetN  in  1  asynchronous active-low reset
layer_color  in  N_LAYERS x 8  output_color from each drawing object, index = layer
requested_x  out  11  current column, driven from h counter register (0..H_TOTAL-1)
requested_y  out  11  current line, driven from v counter register (0..V_TOTAL-1)
frame_start  out  1  one-cycle pulse at start of vertical blanking
rgb_out  out  8  merged pixel color
hsync_n  out  1  active-low horizontal sync
vsync_n  out  1  active-low vertical sync
blank_n  out  1  high in active area
collision_flags  out  N_LAYERS  bit k set if player overlapped layer k in the last completed frame; bit 0 always 0

Behaviour:
- Reset values, asynchronous: h=0, v=0, frame_start=0, rgb_out=0, hsync_n=1, vsync_n=1, blank_n=0, collision_flags=0, collision accumulator=0, all pipeline delay registers cleared to inactive.
- Counters:
  - h increments every cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, v increments and wraps V_TOTAL-1 -> 0.
  - requested_x = h and requested_y = v, both zero-extended to 11 bits.
- frame_start is registered. It is high for exactly one cycle when the counters read (h=0, v=V_ACTIVE), i.e. once per H_TOTAL*V_TOTAL = 420000 cycles.
- Raw per-position flags:
  - active = (h<H_ACTIVE && v<V_ACTIVE)
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491
  - All three are delayed OBJ_LATENCY cycles so they align with layer_color.
- Merge stage, registered; total latency from counter to outputs = OBJ_LATENCY+1 = 2 cycles:
  - If delayed active=0: rgb_out=0.
  - Else rgb_out = layer_color[i] for the lowest index i with layer_color[i] != MASK_VALUE.
  - If no such layer: rgb_out = BG_COLOR.
  - blank_n, hsync_n (= !hs) and vsync_n (= !vs) are registered in the same stage, so all four outputs describe the same pixel.
- Collision:
  - Evaluated only when delayed active=1.
  - For each k>=1: if layer_color[0]!=MASK_VALUE and layer_color[k]!=MASK_VALUE, set accumulator bit k (sticky).
  - In the cycle frame_start is asserted: collision_flags <= accumulator, then the accumulator is cleared.
  - If a hit occurs in that same cycle, it is written into the cleared accumulator and counts toward the next frame (clear first, then OR).
  - The pipeline drains during line 479's horizontal blanking, so no active-area pixel straddles frame_start.
- collision_flags holds its value for the whole next frame; it updates only at frame_start.
- MASK_VALUE on layer 0 is never a collision source, even if other layers are opaque.
- Reset mid-frame returns all state to reset values immediately. The first frame_start after release occurs after 480*800 = 384000 cycles, with the counter at (0,480).
- Width rules: counters are 10-bit internally and zero-extended to 11 bits. Comparisons are unsigned.

Test Plan:
- Reset release, free-run 420000 cycles -> requested_x/y start at 0/0; frame_start pulses exactly once, at cycle 384000; hsync_n low for cycles h=658..753 of each line (656..751 plus 2-cycle output latency); vsync_n low for lines 490..491.
- All layers drive 8'h62 -> rgb_out = BG_COLOR (8'h00) in the active area and 0 in blanking; blank_n high for exactly 640 cycles per active line.
- Pixel (100,50): layer0=8'h62, layer1=8'hE4, layer2=8'hF8 -> rgb_out=8'hE4, two cycles after requested_x=100/requested_y=50.
- Layer0=8'hFF and layer2=8'h1F for one pixel in frame N, with no other overlaps -> collision_flags=4'b0100 after frame N's frame_start, and 4'b0000 after frame N+1's frame_start.
- Opaque layers 0 and 3 overlapping only at h=700 (horizontal blanking) -> collision_flags stays 0 and rgb_out=0.
- Assert resetN low at (h=300, v=200) -> all outputs return to reset values in the same cycle; after release, h=0, v=0 and the next frame_start is 384000 cycles later.
